vga_draw_scheduler: RTL and testbench
=====================================

// Module: vga_draw_scheduler
// PURPOSE
//  Sole writer of the vga_adapter pixel port (x, y, colour, plot) for the Wack-A-Mole display.
//  Serialises a full-screen clear and NUM_REQ rectangle-fill requesters (mole/hole sprites)
//  onto one pixel per cycle. Clear beats boxes; boxes share round-robin. Req/done handshake per requester.
// PARAMETERS
//  SCREEN_W  160  visible columns; vga_x range 0..SCREEN_W-1
//  SCREEN_H  120  visible rows; vga_y range 0..SCREEN_H-1
//  NUM_REQ   4    rectangle requesters (one per mole hole)
//  COLOUR_W  3    colour bits (1 bit/channel)
// PORTS
//  CLOCK_50    in   1             system clock; all state on posedge
//  reset       in   1             async, active-high; clears all state
//  clr_req     in   1             level: fill whole screen with clr_colour
//  clr_colour  in   COLOUR_W      fill colour; stable while clr_req high
//  clr_done    out  1             1-cycle pulse after last clear pixel
//  box_req     in   NUM_REQ       level request per requester
//  box_x       in   8*NUM_REQ     top-left column, slice i = [8i+7:8i]
//  box_y       in   7*NUM_REQ     top-left row
//  box_w       in   8*NUM_REQ     width in pixels (0 = empty)
//  box_h       in   7*NUM_REQ     height in pixels (0 = empty)
//  box_colour  in   COLOUR_W*NUM_REQ  fill colour
//  box_grant   out  NUM_REQ       one-hot, high for the whole service of the winner
//  box_done    out  NUM_REQ       one-hot 1-cycle pulse when winner finished
//  vga_x/vga_y out  8 / 7         pixel address to vga_adapter
//  vga_colour  out  COLOUR_W      pixel colour
//  vga_plot    out  1             write strobe, high only for in-screen pixels
//  busy        out  1             high in any state except IDLE
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: state IDLE, RR pointer 0, all outputs 0 (vga_plot=0 immediately, even mid-draw).
//  States: IDLE -> LOAD -> DRAW -> DONE -> IDLE.
//   IDLE: clr_req wins; else first box_req[i] at/after RR pointer. None -> stay.
//   LOAD (1 cyc): latch origin/size/colour of winner; grant asserted from here to DONE incl.
//         Empty box (w==0 or h==0) -> DONE directly, zero plots.
//   DRAW: one pixel per cycle, raster order: col x0..x0+w-1, then next row, rows y0..y0+h-1.
//         Counters are 9/8 bits wide so x0+w, y0+h never wrap; pixel with x>=SCREEN_W or
//         y>=SCREEN_H is clipped (plot=0, cycle still consumed). Clear = origin 0,0, SCREEN_W x SCREEN_H.
//         Last pixel -> DONE next cycle.
//   DONE (1 cyc): pulse clr_done or box_done[i]; RR pointer := i+1 mod NUM_REQ (box only).
//  Inputs sampled only in IDLE/LOAD; changes during DRAW ignored. Req dropped mid-service ignored.
//  Req still high in IDLE after done = new request (requester must drop req on done).
//  clr_req arriving during a box service waits; it wins at the next IDLE.
//  Service cost: 3 + w*h cycles; full clear = 19203 cycles, 19200 plots.
//  Outputs registered; vga_x/y/colour valid in the same cycle as vga_plot.
// STRUCTURE
//  Package vga_pkg: SCREEN_W/H, COLOUR_W, state encoding, X_W=8/Y_W=7 localparams.
//  Sub-module rr_arbiter (NUM_REQ, req, ptr -> one-hot gnt, combinational); rest is one FSM + raster counters.
// TESTING
//  Clear with clr_colour=3'b000 -> 19200 plots, first (0,0), last (159,119), clr_done 1 cycle after.
//  box0=(10,20,3x2,c=3'b100) -> plots (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), box_done[0] pulse.
//  box_req=4'b1111 held, each dropped on its done -> grant order 0,1,2,3; again with ptr=2 -> 2,3,0,1.
//  clr_req raised during box1 DRAW -> box1 completes intact, then clear granted ahead of pending box2.
//  box3=(158,118,4x4) -> 16 DRAW cycles, only (158,118)(159,118)(158,119)(159,119) plotted.
//  box w=0 -> box_done after LOAD, zero plots; reset asserted mid-clear -> plot=0 async, busy=0, IDLE.

Source files
------------

// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Brief  : Screen geometry, pixel-address widths and draw-FSM state encoding
//          shared by the Wack-A-Mole draw scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  // One extra bit so that origin + size never wraps.
  localparam int CX_W     = X_W + 1;
  localparam int CY_W     = Y_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/vga_draw_scheduler_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin picker; one-hot grant to the first
//          request at or after the pointer, wrapping modulo NUM_REQ.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_draw_scheduler.sv
// ============================================================================
// Module : vga_draw_scheduler
// Brief  : Sole writer of the vga_adapter pixel port; serialises a full-screen
//          clear and NUM_REQ rectangle fills at one pixel per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_draw_scheduler
  import vga_pkg::*;
#(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H,
  parameter int NUM_REQ  = 4,
  parameter int COLOUR_W = vga_pkg::COLOUR_W
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         clr_req,
  input  logic [COLOUR_W-1:0]          clr_colour,
  output logic                         clr_done,
  input  logic [NUM_REQ-1:0]           box_req,
  input  logic [X_W*NUM_REQ-1:0]       box_x,
  input  logic [Y_W*NUM_REQ-1:0]       box_y,
  input  logic [X_W*NUM_REQ-1:0]       box_w,
  input  logic [Y_W*NUM_REQ-1:0]       box_h,
  input  logic [COLOUR_W*NUM_REQ-1:0]  box_colour,
  output logic [NUM_REQ-1:0]           box_grant,
  output logic [NUM_REQ-1:0]           box_done,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot,
  output logic                         busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CX_W-1:0] c_scr_w = CX_W'(SCREEN_W);
  localparam logic [CY_W-1:0] c_scr_h = CY_W'(SCREEN_H);

  state_t                r_state, w_nxt_state;
  logic [NUM_REQ-1:0]    r_gnt, r_box_done;
  logic [PTR_W-1:0]      r_ptr, r_idx, w_arb_idx;
  logic                  r_is_clr, r_clr_done, r_plot, r_busy;
  logic [CX_W-1:0]       r_cx, r_x0, r_xend;
  logic [CY_W-1:0]       r_cy, r_yend;
  logic [COLOUR_W-1:0]   r_colour;
  logic [NUM_REQ-1:0]    w_arb_gnt;

  logic [X_W-1:0]        w_bx [NUM_REQ];
  logic [Y_W-1:0]        w_by [NUM_REQ];
  logic [X_W-1:0]        w_bw [NUM_REQ];
  logic [Y_W-1:0]        w_bh [NUM_REQ];
  logic [COLOUR_W-1:0]   w_bc [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_bx[gi] = box_x[gi*X_W +: X_W];
    assign w_by[gi] = box_y[gi*Y_W +: Y_W];
    assign w_bw[gi] = box_w[gi*X_W +: X_W];
    assign w_bh[gi] = box_h[gi*Y_W +: Y_W];
    assign w_bc[gi] = box_colour[gi*COLOUR_W +: COLOUR_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req (box_req),
    .ptr (r_ptr),
    .gnt (w_arb_gnt)
  );

  always_comb begin
    w_arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_gnt[i]) w_arb_idx = PTR_W'(i);
    end
  end

  // Geometry of the winner, sampled while in LOAD.
  logic [CX_W-1:0]     w_ld_x0, w_ld_w, w_ld_xend;
  logic [CY_W-1:0]     w_ld_y0, w_ld_h, w_ld_yend;
  logic [COLOUR_W-1:0] w_ld_colour;
  logic                w_ld_empty, w_ld_vis;

  assign w_ld_x0     = r_is_clr ? '0 : {1'b0, w_bx[r_idx]};
  assign w_ld_y0     = r_is_clr ? '0 : {1'b0, w_by[r_idx]};
  assign w_ld_w      = r_is_clr ? c_scr_w : {1'b0, w_bw[r_idx]};
  assign w_ld_h      = r_is_clr ? c_scr_h : {1'b0, w_bh[r_idx]};
  assign w_ld_colour = r_is_clr ? clr_colour : w_bc[r_idx];
  assign w_ld_xend   = w_ld_x0 + w_ld_w;
  assign w_ld_yend   = w_ld_y0 + w_ld_h;
  assign w_ld_empty  = (w_ld_w == '0) || (w_ld_h == '0);
  assign w_ld_vis    = (w_ld_x0 < c_scr_w) && (w_ld_y0 < c_scr_h);

  logic [CX_W-1:0] w_cx_inc, w_nx;
  logic [CY_W-1:0] w_cy_inc, w_ny;
  logic            w_x_wrap, w_last, w_nvis, w_to_done;

  assign w_cx_inc = r_cx + CX_W'(1);
  assign w_cy_inc = r_cy + CY_W'(1);
  assign w_x_wrap = (w_cx_inc == r_xend);
  assign w_last   = w_x_wrap && (w_cy_inc == r_yend);
  assign w_nx     = w_x_wrap ? r_x0 : w_cx_inc;
  assign w_ny     = w_x_wrap ? w_cy_inc : r_cy;
  assign w_nvis   = (w_nx < c_scr_w) && (w_ny < c_scr_h);

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE:  if (clr_req || (|box_req)) w_nxt_state = S_LOAD;
      S_LOAD:  w_nxt_state = w_ld_empty ? S_DONE : S_DRAW;
      S_DRAW:  if (w_last) w_nxt_state = S_DONE;
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  assign w_to_done = (r_state != S_DONE) && (w_nxt_state == S_DONE);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt_state;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_gnt      <= '0;
      r_box_done <= '0;
      r_clr_done <= 1'b0;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_is_clr   <= 1'b0;
      r_plot     <= 1'b0;
      r_busy     <= 1'b0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_x0       <= '0;
      r_xend     <= '0;
      r_yend     <= '0;
      r_colour   <= '0;
    end else begin
      r_busy     <= (w_nxt_state != S_IDLE);
      r_plot     <= 1'b0;
      r_clr_done <= w_to_done && r_is_clr;
      r_box_done <= (w_to_done && !r_is_clr) ? r_gnt : '0;
      case (r_state)
        S_IDLE: begin
          if (clr_req) begin
            r_is_clr <= 1'b1;
            r_gnt    <= '0;
          end else if (|box_req) begin
            r_is_clr <= 1'b0;
            r_gnt    <= w_arb_gnt;
            r_idx    <= w_arb_idx;
          end
        end
        S_LOAD: begin
          r_x0     <= w_ld_x0;
          r_xend   <= w_ld_xend;
          r_yend   <= w_ld_yend;
          r_colour <= w_ld_colour;
          r_cx     <= w_ld_x0;
          r_cy     <= w_ld_y0;
          r_plot   <= !w_ld_empty && w_ld_vis;
        end
        S_DRAW: begin
          r_cx   <= w_nx;
          r_cy   <= w_ny;
          // Off-screen pixels still take their cycle, they just do not strobe.
          r_plot <= !w_last && w_nvis;
        end
        S_DONE: begin
          r_gnt    <= '0;
          r_is_clr <= 1'b0;
          if (!r_is_clr)
            r_ptr <= (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + PTR_W'(1);
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  assign clr_done   = r_clr_done;
  assign box_grant  = r_gnt;
  assign box_done   = r_box_done;
  assign vga_x      = r_cx[X_W-1:0];
  assign vga_y      = r_cy[Y_W-1:0];
  assign vga_colour = r_colour;
  assign vga_plot   = r_plot;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_vga_draw_scheduler.sv
// ============================================================================
// Module : tb_vga_draw_scheduler
// Brief  : Directed self-checking bench for vga_draw_scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_draw_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int COLOUR_W = 3;

  logic                        CLOCK_50 = 1'b0;
  logic                        reset    = 1'b1;
  logic                        clr_req  = 1'b0;
  logic [COLOUR_W-1:0]         clr_colour = '0;
  logic                        clr_done;
  logic [NUM_REQ-1:0]          box_req  = '0;
  logic [8*NUM_REQ-1:0]        box_x    = '0;
  logic [7*NUM_REQ-1:0]        box_y    = '0;
  logic [8*NUM_REQ-1:0]        box_w    = '0;
  logic [7*NUM_REQ-1:0]        box_h    = '0;
  logic [COLOUR_W*NUM_REQ-1:0] box_colour = '0;
  logic [NUM_REQ-1:0]          box_grant, box_done;
  logic [7:0]                  vga_x;
  logic [6:0]                  vga_y;
  logic [COLOUR_W-1:0]         vga_colour;
  logic                        vga_plot, busy;

  vga_draw_scheduler #(
    .SCREEN_W (160),
    .SCREEN_H (120),
    .NUM_REQ  (NUM_REQ),
    .COLOUR_W (COLOUR_W)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .clr_req    (clr_req),
    .clr_colour (clr_colour),
    .clr_done   (clr_done),
    .box_req    (box_req),
    .box_x      (box_x),
    .box_y      (box_y),
    .box_w      (box_w),
    .box_h      (box_h),
    .box_colour (box_colour),
    .box_grant  (box_grant),
    .box_done   (box_done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {int x; int y; int c;} pix_t;
  pix_t plots[$];

  int         it;
  logic [3:0] dv, gs;
  logic       dc;

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic set_box(input int i, input logic [7:0] x, input logic [6:0] y,
                         input logic [7:0] w, input logic [6:0] h, input logic [2:0] c);
    box_x[8*i +: 8] = x;
    box_y[7*i +: 7] = y;
    box_w[8*i +: 8] = w;
    box_h[7*i +: 7] = h;
    box_colour[3*i +: 3] = c;
  endtask

  task automatic pulse_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    idle(1);
  endtask

  // Runs until a done pulse, logging plots; behaves as a polite requester
  // by dropping its request on done. Optionally raises clr_req at cycle clr_at.
  task automatic service(input int timeout, input int clr_at, output int iters,
                         output logic [3:0] done_vec, output logic done_clr,
                         output logic [3:0] gnt_seen);
    bit   fin;
    pix_t p;
    iters = 0; done_vec = '0; done_clr = 1'b0; gnt_seen = '0; fin = 1'b0;
    while (!fin) begin
      @(negedge CLOCK_50);
      iters++;
      if (iters == clr_at) clr_req = 1'b1;
      if (gnt_seen == 4'b0 && box_grant != 4'b0) gnt_seen = box_grant;
      if (vga_plot) begin
        p.x = int'(vga_x); p.y = int'(vga_y); p.c = int'(vga_colour);
        plots.push_back(p);
      end
      if (clr_done || box_done != 4'b0) begin
        done_clr = clr_done;
        done_vec = box_done;
        if (clr_done) clr_req = 1'b0;
        box_req = box_req & ~box_done;
        fin = 1'b1;
      end else if (iters >= timeout) begin
        n_cmp++; n_fail++;
        $display("FAIL service_timeout: got no done after %0d cycles, required a done pulse", iters);
        fin = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    idle(2);
    n_cmp++; if (vga_plot !== 1'b0) begin n_fail++; $display("FAIL rst_plot: got %b want 0", vga_plot); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if ({box_grant, box_done, clr_done} !== 9'b0) begin n_fail++;
      $display("FAIL rst_hs: got grant=%b done=%b clr_done=%b want 0", box_grant, box_done, clr_done); end
    n_cmp++; if ({vga_x, vga_y, vga_colour} !== 18'b0) begin n_fail++;
      $display("FAIL rst_pix: got x=%0d y=%0d c=%0d want 0", vga_x, vga_y, vga_colour); end
    reset = 1'b0;
    idle(2);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_clear();
    int bad;
    plots.delete();
    idle(2);
    clr_colour = 3'b000;
    clr_req = 1'b1;
    service(20000, 0, it, dv, dc, gs);
    n_cmp++; if (dc !== 1'b1 || dv !== 4'b0) begin n_fail++; $display("FAIL clr_done: got clr=%b box=%b want 1/0000", dc, dv); end
    n_cmp++; if (gs !== 4'b0) begin n_fail++; $display("FAIL clr_grant: got %b want 0000", gs); end
    n_cmp++; if (it !== 19202) begin n_fail++; $display("FAIL clr_cycles: got %0d want 19202", it); end
    n_cmp++; if (plots.size() !== 19200) begin n_fail++; $display("FAIL clr_plots: got %0d want 19200", plots.size()); end
    if (plots.size() == 19200) begin
      n_cmp++; if (plots[0].x !== 0 || plots[0].y !== 0) begin n_fail++;
        $display("FAIL clr_first: got (%0d,%0d) want (0,0)", plots[0].x, plots[0].y); end
      n_cmp++; if (plots[19199].x !== 159 || plots[19199].y !== 119) begin n_fail++;
        $display("FAIL clr_last: got (%0d,%0d) want (159,119)", plots[19199].x, plots[19199].y); end
      bad = 0;
      for (int k = 0; k < 19200; k++)
        if (plots[k].x != k % 160 || plots[k].y != k / 160 || plots[k].c != 0) bad++;
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL clr_raster: got %0d bad pixels want 0", bad); end
    end
    @(negedge CLOCK_50);
    n_cmp++; if (clr_done !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL clr_after: got clr_done=%b busy=%b want 0/0", clr_done, busy); end
  endtask

  task automatic test_single_box();
    int ex[6] = '{10, 11, 12, 10, 11, 12};
    int ey[6] = '{20, 20, 20, 21, 21, 21};
    plots.delete();
    set_box(0, 8'd10, 7'd20, 8'd3, 7'd2, 3'b100);
    box_req = 4'b0001;
    service(100, 0, it, dv, dc, gs);
    n_cmp++; if (it !== 8) begin n_fail++; $display("FAIL box0_cycles: got %0d want 8", it); end
    n_cmp++; if (dv !== 4'b0001 || dc !== 1'b0) begin n_fail++; $display("FAIL box0_done: got %b/%b want 0001/0", dv, dc); end
    n_cmp++; if (gs !== 4'b0001) begin n_fail++; $display("FAIL box0_grant: got %b want 0001", gs); end
    n_cmp++; if (plots.size() !== 6) begin n_fail++; $display("FAIL box0_count: got %0d want 6", plots.size()); end
    for (int k = 0; k < 6 && k < plots.size(); k++) begin
      n_cmp++;
      if (plots[k].x !== ex[k] || plots[k].y !== ey[k] || plots[k].c !== 4) begin n_fail++;
        $display("FAIL box0_pix%0d: got (%0d,%0d,c%0d) want (%0d,%0d,c4)", k, plots[k].x, plots[k].y, plots[k].c, ex[k], ey[k]); end
    end
    @(negedge CLOCK_50);
    n_cmp++; if (box_done !== 4'b0 || box_grant !== 4'b0) begin n_fail++;
      $display("FAIL box0_after: got done=%b grant=%b want 0/0", box_done, box_grant); end
  endtask

  task automatic test_round_robin();
    logic [3:0] e1[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] e2[4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    pulse_reset();
    for (int i = 0; i < 4; i++) set_box(i, 8'(i), 7'd0, 8'd1, 7'd1, 3'(i + 1));
    box_req = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      service(100, 0, it, dv, dc, gs);
      n_cmp++; if (gs !== e1[r] || dv !== e1[r]) begin n_fail++;
        $display("FAIL rr0_round%0d: got grant=%b done=%b want %b", r, gs, dv, e1[r]); end
    end
    idle(2);
    box_req = 4'b0010;
    service(100, 0, it, dv, dc, gs);
    box_req = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      service(100, 0, it, dv, dc, gs);
      n_cmp++; if (gs !== e2[r] || dv !== e2[r]) begin n_fail++;
        $display("FAIL rr2_round%0d: got grant=%b done=%b want %b", r, gs, dv, e2[r]); end
    end
  endtask

  task automatic test_clear_priority();
    int bad;
    pulse_reset();
    set_box(1, 8'd30, 7'd40, 8'd4, 7'd4, 3'b010);
    set_box(2, 8'd50, 7'd60, 8'd2, 7'd1, 3'b001);
    clr_colour = 3'b111;
    plots.delete();
    box_req = 4'b0110;
    service(100, 5, it, dv, dc, gs);
    n_cmp++; if (gs !== 4'b0010 || dv !== 4'b0010 || dc !== 1'b0) begin n_fail++;
      $display("FAIL pri_box1: got grant=%b done=%b clr=%b want 0010/0010/0", gs, dv, dc); end
    n_cmp++; if (it !== 18) begin n_fail++; $display("FAIL pri_box1_cycles: got %0d want 18", it); end
    bad = (plots.size() == 16) ? 0 : 1;
    for (int k = 0; k < 16 && k < plots.size(); k++)
      if (plots[k].x != 30 + k % 4 || plots[k].y != 40 + k / 4 || plots[k].c != 2) bad++;
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL pri_box1_pix: got %0d errors (n=%0d) want 0", bad, plots.size()); end
    plots.delete();
    service(20000, 0, it, dv, dc, gs);
    n_cmp++; if (dc !== 1'b1 || dv !== 4'b0 || gs !== 4'b0) begin n_fail++;
      $display("FAIL pri_clear: got clr=%b done=%b grant=%b want 1/0000/0000", dc, dv, gs); end
    n_cmp++; if (it !== 19203 || plots.size() !== 19200) begin n_fail++;
      $display("FAIL pri_clear_len: got cycles=%0d plots=%0d want 19203/19200", it, plots.size()); end
    if (plots.size() > 0) begin
      n_cmp++; if (plots[0].c !== 7) begin n_fail++; $display("FAIL pri_clear_colour: got %0d want 7", plots[0].c); end
    end
    plots.delete();
    service(100, 0, it, dv, dc, gs);
    n_cmp++; if (gs !== 4'b0100 || dv !== 4'b0100) begin n_fail++;
      $display("FAIL pri_box2: got grant=%b done=%b want 0100", gs, dv); end
    n_cmp++; if (plots.size() !== 2) begin n_fail++; $display("FAIL pri_box2_count: got %0d want 2", plots.size()); end
    else begin
      n_cmp++; if (plots[1].x !== 51 || plots[1].y !== 60 || plots[1].c !== 1) begin n_fail++;
        $display("FAIL pri_box2_pix: got (%0d,%0d,c%0d) want (51,60,c1)", plots[1].x, plots[1].y, plots[1].c); end
    end
  endtask

  task automatic test_clip();
    int ex[4] = '{158, 159, 158, 159};
    int ey[4] = '{118, 118, 119, 119};
    plots.delete();
    idle(2);
    set_box(3, 8'd158, 7'd118, 8'd4, 7'd4, 3'b011);
    box_req = 4'b1000;
    service(100, 0, it, dv, dc, gs);
    n_cmp++; if (it !== 18 || dv !== 4'b1000) begin n_fail++;
      $display("FAIL clip_done: got cycles=%0d done=%b want 18/1000", it, dv); end
    n_cmp++; if (plots.size() !== 4) begin n_fail++; $display("FAIL clip_count: got %0d want 4", plots.size()); end
    for (int k = 0; k < 4 && k < plots.size(); k++) begin
      n_cmp++;
      if (plots[k].x !== ex[k] || plots[k].y !== ey[k] || plots[k].c !== 3) begin n_fail++;
        $display("FAIL clip_pix%0d: got (%0d,%0d,c%0d) want (%0d,%0d,c3)", k, plots[k].x, plots[k].y, plots[k].c, ex[k], ey[k]); end
    end
  endtask

  task automatic test_empty();
    plots.delete();
    idle(2);
    set_box(2, 8'd5, 7'd5, 8'd0, 7'd3, 3'b001);
    box_req = 4'b0100;
    service(100, 0, it, dv, dc, gs);
    n_cmp++; if (it !== 2 || dv !== 4'b0100 || plots.size() !== 0) begin n_fail++;
      $display("FAIL empty_w: got cycles=%0d done=%b plots=%0d want 2/0100/0", it, dv, plots.size()); end
    idle(2);
    set_box(0, 8'd5, 7'd5, 8'd3, 7'd0, 3'b001);
    box_req = 4'b0001;
    service(100, 0, it, dv, dc, gs);
    n_cmp++; if (it !== 2 || dv !== 4'b0001 || plots.size() !== 0) begin n_fail++;
      $display("FAIL empty_h: got cycles=%0d done=%b plots=%0d want 2/0001/0", it, dv, plots.size()); end
  endtask

  task automatic test_reset_mid_clear();
    idle(2);
    clr_colour = 3'b101;
    clr_req = 1'b1;
    repeat (200) @(negedge CLOCK_50);
    n_cmp++; if (vga_plot !== 1'b1 || busy !== 1'b1) begin n_fail++;
      $display("FAIL midclr_active: got plot=%b busy=%b want 1/1", vga_plot, busy); end
    #2;
    reset = 1'b1;
    clr_req = 1'b0;
    #1;
    n_cmp++; if (vga_plot !== 1'b0 || busy !== 1'b0 || box_grant !== 4'b0) begin n_fail++;
      $display("FAIL midclr_async: got plot=%b busy=%b grant=%b want 0/0/0", vga_plot, busy, box_grant); end
    @(negedge CLOCK_50);
    reset = 1'b0;
    idle(3);
    n_cmp++; if (vga_plot !== 1'b0 || busy !== 1'b0 || clr_done !== 1'b0) begin n_fail++;
      $display("FAIL midclr_idle: got plot=%b busy=%b clr_done=%b want 0/0/0", vga_plot, busy, clr_done); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_single_box();
    test_round_robin();
    test_clear_priority();
    test_clip();
    test_empty();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
